// File: rtl/dfe_interp_pkg.sv
// Shared definitions for the 3/2 transmit-side fractional interpolator.
//
// Contents:
//   DATA_W, COEF_W, TAPS_PER_PHASE   default datapath sizes (Q1.15 samples and coefficients)
//   state_e                          FSM state encoding used by frac_interp_3_2
//   nextPhase()                      phase advance rule, p -> (p + 2) mod 3
//   phaseIndex()                     maps (phase, tap) to a prototype coefficient index
//   coefAt()                         24-tap prototype lowpass, Q1.15
//
// The prototype is a Hamming-windowed sinc with cutoff fs_in/2 at the 3x
// upsampled rate. Each polyphase branch h[p + 3k] sums to 32767 or 32766,
// so every phase has unity DC gain (the x3 interpolation gain is folded in).
package dfe_interp_pkg;

   localparam int DATA_W         = 16;
   localparam int COEF_W         = 16;
   localparam int TAPS_PER_PHASE = 8;
   localparam int NUM_PHASES     = 3;
   localparam int PROTO_LEN      = NUM_PHASES * TAPS_PER_PHASE;
   localparam int TAP_IDX_W      = $clog2(TAPS_PER_PHASE);
   localparam int ACC_W          = DATA_W + COEF_W + $clog2(TAPS_PER_PHASE);

   typedef enum logic [1:0] {
      ST_WAIT_IN = 2'd0,
      ST_MAC     = 2'd1,
      ST_OUT     = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

   // Output n uses phase 2n mod 3, so consecutive outputs step the phase by 2.
   function automatic logic [1:0] nextPhase(input logic [1:0] phase);
      logic [1:0] result;
      case (phase)
         2'd0:    result = 2'd2;
         2'd1:    result = 2'd0;
         default: result = 2'd1;
      endcase
      return result;
   endfunction

   // Tap k of branch p uses prototype coefficient h[p + 3k].
   function automatic logic [4:0] phaseIndex(input logic [1:0] phase,
                                             input logic [TAP_IDX_W-1:0] tap);
      return 5'(phase) + 5'(tap) * 5'd3;
   endfunction

   // Symmetric prototype: h[i] == h[23 - i].
   function automatic logic signed [COEF_W-1:0] coefAt(input logic [4:0] idx);
      logic signed [COEF_W-1:0] c;
      case (idx)
         5'd0:    c = -16'sd115;
         5'd1:    c = -16'sd344;
         5'd2:    c = -16'sd288;
         5'd3:    c =  16'sd478;
         5'd4:    c =  16'sd1517;
         5'd5:    c =  16'sd1157;
         5'd6:    c = -16'sd1707;
         5'd7:    c = -16'sd4978;
         5'd8:    c = -16'sd3667;
         5'd9:    c =  16'sd5662;
         5'd10:   c =  16'sd20188;
         5'd11:   c =  16'sd31247;
         5'd12:   c =  16'sd31247;
         5'd13:   c =  16'sd20188;
         5'd14:   c =  16'sd5662;
         5'd15:   c = -16'sd3667;
         5'd16:   c = -16'sd4978;
         5'd17:   c = -16'sd1707;
         5'd18:   c =  16'sd1157;
         5'd19:   c =  16'sd1517;
         5'd20:   c =  16'sd478;
         5'd21:   c = -16'sd288;
         5'd22:   c = -16'sd344;
         5'd23:   c = -16'sd115;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/interp_mac.sv
// Sequential signed multiply-accumulate with round-and-saturate output stage.
//
// Ports:
//   clk_i      in   system clock
//   rst_ni     in   asynchronous active-low reset, clears the accumulator
//   clear_i    in   synchronous accumulator clear (wins over en_i)
//   en_i       in   add sample_i * coef_i into the accumulator this cycle
//   sample_i   in   signed Q1.15 sample
//   coef_i     in   signed Q1.15 coefficient
//   result_o   out  accumulator rounded to Q1.15 and clamped to the sample range (combinational)
module interp_mac #(
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int ACC_WIDTH  = 35
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic                         en_i,
   input  logic signed [DATA_WIDTH-1:0] sample_i,
   input  logic signed [COEF_WIDTH-1:0] coef_i,
   output logic signed [DATA_WIDTH-1:0] result_o
);

   localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

   // Half an output LSB, added before the arithmetic shift for round-half-up.
   localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS =
      {{(ACC_WIDTH-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [PROD_WIDTH-1:0] product;
   logic signed [ACC_WIDTH-1:0]  productExt;
   logic signed [ACC_WIDTH-1:0]  acc_q;
   logic signed [ACC_WIDTH-1:0]  rounded;
   logic signed [ACC_WIDTH-1:0]  scaled;

   // Full-precision product, sign-extended so the accumulator never wraps
   // across TAPS_PH full-scale terms.
   assign product    = sample_i * coef_i;
   assign productExt = {{(ACC_WIDTH-PROD_WIDTH){product[PROD_WIDTH-1]}}, product};

   // Accumulator: a clear always starts a fresh output, otherwise one tap per enabled cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else if (clear_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_q + productExt;
      end
   end

   // Back to Q1.15: round, drop the coefficient fraction bits, then clamp
   // instead of letting large overshoots wrap around.
   always_comb begin
      rounded = acc_q + ROUND_BIAS;
      scaled  = rounded >>> (COEF_WIDTH - 1);
      if (scaled > SAT_MAX) begin
         result_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (scaled < SAT_MIN) begin
         result_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         result_o = scaled[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/frac_interp_3_2.sv
// Transmit-side 3/2 fractional interpolator: accepts samples at fs and emits
// three outputs for every two inputs via a 3-phase polyphase FIR evaluated
// with a single sequential MAC (TAPS_PH cycles per output).
//
// Ports:
//   clk_i            in   system clock (18 MHz)
//   rst_ni           in   asynchronous active-low reset
//   filter_enable_i  in   1 = run; 0 = finish the output in progress, then hold
//   in_valid_i       in   data_in_i is valid
//   in_ready_o       out  block accepts data_in_i this cycle (registered)
//   data_in_i        in   signed Q1.15 input sample
//   out_valid_o      out  one-cycle strobe: data_out_o is new
//   data_out_o       out  signed Q1.15 output sample, held between strobes
module frac_interp_3_2
   import dfe_interp_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int COEF_WIDTH = COEF_W,
   parameter int TAPS_PH    = TAPS_PER_PHASE
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         filter_enable_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic signed [DATA_WIDTH-1:0] data_in_i,
   output logic                         out_valid_o,
   output logic signed [DATA_WIDTH-1:0] data_out_o
);

   localparam int TAP_W     = $clog2(TAPS_PH);
   localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS_PH);

   state_e                      state_q;
   logic [1:0]                  phase_q;
   logic [1:0]                  phase_d;
   logic                        needIn_q;
   logic                        needIn_d;
   logic [TAP_W-1:0]            tap_q;
   logic signed [DATA_WIDTH-1:0] delayLine_q [TAPS_PH];
   logic                        inReady_q;
   logic                        outValid_q;
   logic signed [DATA_WIDTH-1:0] dataOut_q;

   logic                        accept;
   logic                        macClear;
   logic                        macEn;
   logic signed [DATA_WIDTH-1:0] macSample;
   logic signed [COEF_WIDTH-1:0] macCoef;
   logic signed [DATA_WIDTH-1:0] macResult;

   // Handshake, phase bookkeeping and the coefficient/sample mux for the
   // current tap. A phase-0 output is always followed by a phase-2 output on
   // the same input, which is why only phases 1 and 2 demand a new sample.
   always_comb begin
      accept    = 1'b0;
      phase_d   = nextPhase(phase_q);
      needIn_d  = (phase_q != 2'd0);
      macClear  = 1'b0;
      macEn     = 1'b0;
      macSample = delayLine_q[tap_q];
      macCoef   = coefAt(phaseIndex(phase_q, tap_q));
      if (state_q == ST_WAIT_IN && needIn_q && inReady_q && in_valid_i) begin
         accept = 1'b1;
      end
      if (accept || state_q == ST_OUT) begin
         macClear = 1'b1;
      end
      if (state_q == ST_MAC) begin
         macEn = 1'b1;
      end
   end

   interp_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (macClear),
      .en_i     (macEn),
      .sample_i (macSample),
      .coef_i   (macCoef),
      .result_o (macResult)
   );

   // Control FSM with registered handshake outputs. filter_enable_i only gates
   // new acceptances and new MAC starts; an output already in progress always
   // completes and strobes. The accumulator is cleared in OUT, so a later
   // HOLD -> MAC restart begins from zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_WAIT_IN;
         phase_q    <= 2'd0;
         needIn_q   <= 1'b1;
         tap_q      <= '0;
         inReady_q  <= 1'b0;
         outValid_q <= 1'b0;
         dataOut_q  <= '0;
         for (int k = 0; k < TAPS_PH; k++) begin
            delayLine_q[k] <= '0;
         end
      end else begin
         outValid_q <= 1'b0;
         case (state_q)
            ST_WAIT_IN: begin
               if (accept) begin
                  delayLine_q[0] <= data_in_i;
                  for (int k = TAPS_PH - 1; k > 0; k--) begin
                     delayLine_q[k] <= delayLine_q[k-1];
                  end
                  tap_q     <= '0;
                  inReady_q <= 1'b0;
                  state_q   <= ST_MAC;
               end else begin
                  inReady_q <= filter_enable_i;
               end
            end
            ST_MAC: begin
               if (tap_q == TAP_W'(TAPS_PH - 1)) begin
                  tap_q   <= '0;
                  state_q <= ST_OUT;
               end else begin
                  tap_q <= tap_q + 1'b1;
               end
            end
            ST_OUT: begin
               dataOut_q  <= macResult;
               outValid_q <= 1'b1;
               phase_q    <= phase_d;
               needIn_q   <= needIn_d;
               tap_q      <= '0;
               if (needIn_d) begin
                  inReady_q <= filter_enable_i;
                  state_q   <= ST_WAIT_IN;
               end else if (filter_enable_i) begin
                  state_q <= ST_MAC;
               end else begin
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (filter_enable_i) begin
                  tap_q   <= '0;
                  state_q <= ST_MAC;
               end
            end
            default: begin
               state_q <= ST_WAIT_IN;
            end
         endcase
      end
   end

   assign in_ready_o  = inReady_q;
   assign out_valid_o = outValid_q;
   assign data_out_o  = dataOut_q;

endmodule

// File: tb/tb_frac_interp_3_2.sv
// Self-checking bench for frac_interp_3_2. Accepted inputs feed a reference
// model that evaluates y[n] = sat(round(sum_k x[floor(2n/3)-k] * h[(2n mod 3)+3k]))
// and queues the expected outputs; a monitor pops one entry per out_valid strobe.
module tb_frac_interp_3_2;

   logic              clk = 1'b0;
   logic              rstN = 1'b1;
   logic              filterEnable = 1'b0;
   logic              inValid = 1'b0;
   logic              inReady;
   logic signed [15:0] dataIn = '0;
   logic              outValid;
   logic signed [15:0] dataOut;

   int checks = 0;
   int errors = 0;
   int strobeCount = 0;
   int satPos = 0;
   int satNeg = 0;
   int hist[$];
   int expQ[$];
   int nOut = 0;

   int coefTab [24] = '{-115, -344, -288, 478, 1517, 1157, -1707, -4978,
                        -3667, 5662, 20188, 31247, 31247, 20188, 5662, -3667,
                        -4978, -1707, 1157, 1517, 478, -288, -344, -115};
   int satPat [8] = '{-32768, 32767, -32768, 32767, 32767, -32768, 32767, -32768};

   // 18 MHz nominal; a 10 ns period keeps the arithmetic simple.
   always #5 clk = ~clk;

   frac_interp_3_2 dut (
      .clk_i           (clk),
      .rst_ni          (rstN),
      .filter_enable_i (filterEnable),
      .in_valid_i      (inValid),
      .in_ready_o      (inReady),
      .data_in_i       (dataIn),
      .out_valid_o     (outValid),
      .data_out_o      (dataOut)
   );

   // One comparison: counts it, and reports it when actual and expected differ.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Reference output n computed straight from the interpolation rule.
   function automatic int refOutput(input int n);
      int p;
      int j;
      longint acc;
      p = (2 * n) % 3;
      j = (2 * n) / 3;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         if (j - k >= 0) begin
            acc += longint'(hist[j - k]) * longint'(coefTab[p + 3 * k]);
         end
      end
      acc = (acc + 64'sd16384) >>> 15;
      if (acc > 32767) return 32767;
      if (acc < -32768) return -32768;
      return int'(acc);
   endfunction

   // Every accepted sample unlocks the outputs whose source index it completes.
   task automatic recordAccept(input int sample);
      hist.push_back(sample);
      while ((2 * nOut) / 3 <= hist.size() - 1) begin
         expQ.push_back(refOutput(nOut));
         nOut++;
      end
   endtask

   // Presents one sample and keeps in_valid high until it has been taken.
   task automatic applyStimulus(input int sample);
      int waitCnt;
      dataIn  = sample[15:0];
      inValid = 1'b1;
      waitCnt = 0;
      while (inReady !== 1'b1 && waitCnt < 200) begin
         @(negedge clk);
         waitCnt++;
      end
      if (inReady !== 1'b1) begin
         checkOutput("acceptTimeout", 0, 1);
         inValid = 1'b0;
      end else begin
         recordAccept(sample);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic idleCycles(input int n);
      inValid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drainQueue();
      int cnt;
      inValid = 1'b0;
      cnt = 0;
      while (expQ.size() > 0 && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("drainPending", expQ.size(), 0);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge, and the
   // model restarts at phase 0 with an empty history.
   task automatic doReset();
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("resetInReady", int'(inReady), 0);
      checkOutput("resetOutValid", int'(outValid), 0);
      checkOutput("resetDataOut", int'(dataOut), 0);
      hist.delete();
      expQ.delete();
      nOut = 0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("readyAfterReset", int'(inReady), 1);
   endtask

   // Monitor: every strobe must match the oldest expected output.
   always @(negedge clk) begin
      if (rstN && outValid === 1'b1) begin
         strobeCount++;
         if (dataOut == 16'sh7fff) satPos++;
         if (dataOut == 16'sh8000) satNeg++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedStrobe actual=%0d expected=no strobe", dataOut);
         end else begin
            checkOutput("dataOut", int'(dataOut), expQ.pop_front());
         end
      end
   end

   // Hang guard, far beyond the normal run length.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      filterEnable = 1'b1;
      inValid = 1'b0;

      $display("[TB] reset");
      doReset();

      $display("[TB] impulse");
      applyStimulus(32767);
      repeat (16) applyStimulus(0);
      drainQueue();

      $display("[TB] dc");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(16384);
         if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 5));
      end
      drainQueue();
      checkOutput("dcLevel", int'(dataOut >= 16383 && dataOut <= 16385), 1);

      $display("[TB] random");
      for (int i = 0; i < 150; i++) begin
         applyStimulus(int'($urandom_range(0, 65535)) - 32768);
         if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 12));
      end
      drainQueue();

      $display("[TB] saturation");
      doReset();
      satPos = 0;
      satNeg = 0;
      applyStimulus(0);
      for (int i = 0; i < 8; i++) applyStimulus(satPat[i]);
      for (int i = 0; i < 8; i++) applyStimulus((satPat[i] > 0) ? -32768 : 32767);
      for (int i = 0; i < 40; i++) applyStimulus((i % 2 == 0) ? 32767 : -32768);
      repeat (10) applyStimulus(0);
      drainQueue();
      checkOutput("satPosSeen", int'(satPos > 0), 1);
      checkOutput("satNegSeen", int'(satNeg > 0), 1);

      $display("[TB] rate");
      doReset();
      base = strobeCount;
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(int'($urandom_range(0, 65535)) - 32768);
      end
      drainQueue();
      checkOutput("rateStrobes", strobeCount - base, 3000);

      $display("[TB] enable drop");
      doReset();
      applyStimulus(12345);
      inValid = 1'b0;
      base = strobeCount;
      @(negedge clk);
      filterEnable = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("enableDropStrobes", strobeCount - base, 1);
      checkOutput("holdPending", expQ.size(), 1);
      checkOutput("holdInReady", int'(inReady), 0);
      filterEnable = 1'b1;
      drainQueue();
      @(negedge clk);
      checkOutput("resumeInReady", int'(inReady), 1);

      $display("[TB] reset mid-mac");
      applyStimulus(-20000);
      applyStimulus(15000);
      applyStimulus(30000);
      inValid = 1'b0;
      repeat (3) @(negedge clk);
      doReset();
      base = strobeCount;
      repeat (20) @(negedge clk);
      checkOutput("noStrobeAfterReset", strobeCount - base, 0);
      applyStimulus(32767);
      repeat (10) applyStimulus(0);
      drainQueue();

      checkOutput("finalQueueEmpty", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
